piso_tx_sched: RTL and testbench



---
 rtl/piso_tx_sched_pkg.sv | 23 ++
 rtl/piso_tx_sched_if.sv | 31 +++
 rtl/piso_tx_sched_rr_arbiter.sv | 33 +++
 rtl/piso_tx_sched.sv | 147 ++++++++++++++
 tb/tb_piso_tx_sched.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/piso_tx_sched_pkg.sv
// Shared types and sizing helpers for the PISO transmit scheduler.
package piso_tx_sched_pkg;

  localparam int DEF_WIDTH      = 129;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_GAP_CYCLES = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // Index width that never collapses to zero bits.
  function automatic int bits_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_W = bits_for(DEF_WIDTH);
  localparam int SRC_W = bits_for(DEF_NUM_REQ);

endpackage

// File: rtl/piso_tx_sched_if.sv
// Requester/shifter-facing bus of the transmit scheduler.
interface piso_tx_sched_if
  import piso_tx_sched_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_REQ = DEF_NUM_REQ
);
  localparam int SW = bits_for(NUM_REQ);

  logic                       en;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*WIDTH-1:0]   req_data;
  logic [NUM_REQ-1:0]         ack;
  logic                       shift_load;
  logic [WIDTH-1:0]           shift_din;
  logic                       frame_valid;
  logic                       frame_last;
  logic [SW-1:0]              frame_src;
  logic                       busy;

  modport slave (
    input  en, req, req_data,
    output ack, shift_load, shift_din, frame_valid, frame_last, frame_src, busy
  );

  modport master (
    output en, req, req_data,
    input  ack, shift_load, shift_din, frame_valid, frame_last, frame_src, busy
  );

endinterface

// File: rtl/piso_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr.
module rr_arbiter
  import piso_tx_sched_pkg::*;
#(
  parameter int N  = DEF_NUM_REQ,
  parameter int IW = bits_for(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int pos;

  // Scan N positions starting at ptr, wrapping; the first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!valid && req[pos]) begin
        valid      = 1'b1;
        grant[pos] = 1'b1;
        idx        = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/piso_tx_sched.sv
// Transmit scheduler feeding a WIDTH-bit parallel-in/serial-out shifter.
//
// state | meaning
// IDLE  | waiting for en and a request; arbitration and word capture here
// LOAD  | one cycle: shifter load pulse and ack to the winner
// SHIFT | WIDTH cycles of shifting, count runs 0..WIDTH-1
// GAP   | GAP_CYCLES idle cycles before the next grant
module piso_tx_sched
  import piso_tx_sched_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  piso_tx_sched_if.slave   bus
);

  localparam int CW = bits_for(WIDTH);
  localparam int SW = bits_for(NUM_REQ);
  localparam int GW = bits_for(GAP_CYCLES + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_INIT = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [SW-1:0] SRC_MAX  = SW'(NUM_REQ - 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [WIDTH-1:0]    data_q;
  logic [SW-1:0]       src_q;
  logic [SW-1:0]       ptr_q;
  logic                fv_q, fl_q;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [SW-1:0]       arb_idx;
  logic                arb_valid;
  logic [WIDTH-1:0]    word_sel;
  logic                take;
  logic                count_last;
  logic                load_c;
  logic [NUM_REQ-1:0]  ack_c;

  rr_arbiter #(.N(NUM_REQ), .IW(SW)) u_arb (
    .req   (bus.req),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // One-hot AND-OR select of the winning requester's word.
  always_comb begin
    word_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) word_sel = word_sel | bus.req_data[i*WIDTH +: WIDTH];
    end
  end

  assign take       = (state_q == ST_IDLE) && bus.en && arb_valid;
  assign count_last = (count_q == CNT_LAST);

  // Next-state, counters and the LOAD-cycle strobes.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    gap_d   = gap_q;
    load_c  = 1'b0;
    ack_c   = '0;
    case (state_q)
      ST_IDLE: begin
        if (take) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        load_c        = 1'b1;
        ack_c[src_q]  = 1'b1;
        count_d       = '0;
        state_d       = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (count_last) begin
          count_d = '0;
          if (GAP_CYCLES > 0) begin
            state_d = ST_GAP;
            gap_d   = GAP_INIT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      gap_q   <= gap_d;
    end
  end

  // Capture word, source and advance the round-robin pointer on a grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      src_q  <= '0;
      ptr_q  <= '0;
    end else if (take) begin
      data_q <= word_sel;
      src_q  <= arb_idx;
      ptr_q  <= (arb_idx == SRC_MAX) ? '0 : arb_idx + 1'b1;
    end
  end

  // Delay frame qualifiers one cycle to line up with the shifter's registered dout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fv_q <= 1'b0;
      fl_q <= 1'b0;
    end else begin
      fv_q <= (state_q == ST_SHIFT);
      fl_q <= (state_q == ST_SHIFT) && count_last;
    end
  end

  assign bus.ack         = ack_c;
  assign bus.shift_load  = load_c;
  assign bus.shift_din   = data_q;
  assign bus.frame_valid = fv_q;
  assign bus.frame_last  = fl_q;
  assign bus.frame_src   = src_q;
  assign bus.busy        = (state_q != ST_IDLE) || fv_q;

endmodule

// File: tb/tb_piso_tx_sched.sv
// Scoreboard bench: two schedulers (GAP_CYCLES=1 and 0) with a shifter model each.
module tb_piso_tx_sched;
  import piso_tx_sched_pkg::*;

  localparam int W = 129;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  piso_tx_sched_if #(.WIDTH(W), .NUM_REQ(N)) bif0 ();
  piso_tx_sched_if #(.WIDTH(W), .NUM_REQ(N)) bif1 ();

  piso_tx_sched #(.WIDTH(W), .NUM_REQ(N), .GAP_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .bus(bif0.slave));
  piso_tx_sched #(.WIDTH(W), .NUM_REQ(N), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bif1.slave));

  logic [N-1:0] ack_s [2];
  logic         load_s [2];
  logic [W-1:0] din_s [2];
  logic         fv_s [2];
  logic         fl_s [2];
  logic [1:0]   src_s [2];
  logic         busy_s [2];

  assign ack_s[0] = bif0.ack;         assign ack_s[1] = bif1.ack;
  assign load_s[0] = bif0.shift_load; assign load_s[1] = bif1.shift_load;
  assign din_s[0] = bif0.shift_din;   assign din_s[1] = bif1.shift_din;
  assign fv_s[0] = bif0.frame_valid;  assign fv_s[1] = bif1.frame_valid;
  assign fl_s[0] = bif0.frame_last;   assign fl_s[1] = bif1.frame_last;
  assign src_s[0] = bif0.frame_src;   assign src_s[1] = bif1.frame_src;
  assign busy_s[0] = bif0.busy;       assign busy_s[1] = bif1.busy;

  // Shifter model: load does not touch dout; otherwise shift out MSB first.
  logic [W-1:0] sr [2];
  logic         dout [2];
  always @(posedge clk or negedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        sr[k]   <= '0;
        dout[k] <= 1'b0;
      end else if (load_s[k]) begin
        sr[k] <= din_s[k];
      end else begin
        dout[k] <= sr[k][W-1];
        sr[k]   <= {sr[k][W-2:0], 1'b0};
      end
    end
  end

  typedef struct {
    int           inst;
    int           src;
    logic [W-1:0] word;
    int           gap;
  } exp_t;

  exp_t ack_q[$];
  exp_t frm_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_i(input string nm, input int act, input int want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, want);
    end
  endtask

  task automatic chk_w(input string nm, input logic [W-1:0] act, input logic [W-1:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, want);
    end
  endtask

  task automatic expect_grant(input int inst, input int src, input logic [W-1:0] word, input int gap);
    exp_t e;
    e.inst = inst; e.src = src; e.word = word; e.gap = gap;
    ack_q.push_back(e);
    frm_q.push_back(e);
  endtask

  // Monitor: pops expectations on each ack and on each completed frame.
  logic [W-1:0] bits [2];
  int           nbits [2] = '{0, 0};
  int           src0 [2];
  logic         src_ok [2];
  int           last_ack [2] = '{0, 0};
  exp_t         mon_e;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        nbits[k] = 0;
      end else begin
        if (ack_s[k] != '0) begin
          if (ack_q.size() == 0) begin
            chk_i("unexpected ack", int'(ack_s[k]), 0);
          end else begin
            mon_e = ack_q.pop_front();
            chk_i("ack instance", k, mon_e.inst);
            chk_i("ack vector and load", (int'(ack_s[k]) << 1) | int'(load_s[k]),
                  ((1 << mon_e.src) << 1) | 1);
            if (mon_e.gap >= 0) chk_i("load spacing", cyc - last_ack[k], mon_e.gap);
          end
          last_ack[k] = cyc;
        end
        if (fv_s[k]) begin
          if (nbits[k] == 0) begin
            src0[k]   = int'(src_s[k]);
            src_ok[k] = 1'b1;
          end else if (int'(src_s[k]) != src0[k]) begin
            src_ok[k] = 1'b0;
          end
          bits[k]  = {bits[k][W-2:0], dout[k]};
          nbits[k] = nbits[k] + 1;
          if (fl_s[k]) begin
            if (frm_q.size() == 0) begin
              chk_i("unexpected frame", nbits[k], 0);
            end else begin
              mon_e = frm_q.pop_front();
              chk_i("frame instance", k, mon_e.inst);
              chk_i("frame length", nbits[k], W);
              chk_w("frame word", bits[k], mon_e.word);
              chk_i("frame_src", src0[k], mon_e.src);
              chk_i("frame_src held", int'(src_ok[k]), 1);
            end
            nbits[k] = 0;
          end else if (nbits[k] >= W) begin
            chk_i("frame_last missing at bit", nbits[k], W - 1);
            nbits[k] = 0;
          end
        end else if (nbits[k] != 0) begin
          chk_i("frame ended without frame_last", nbits[k], 0);
          nbits[k] = 0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic e, input logic [N-1:0] r);
    if (k == 0) begin bif0.en = e; bif0.req = r; end
    else        begin bif1.en = e; bif1.req = r; end
  endtask

  task automatic put_word(input int k, input int i, input logic [W-1:0] w);
    if (k == 0) bif0.req_data[i*W +: W] = w;
    else        bif1.req_data[i*W +: W] = w;
  endtask

  task automatic wait_ack(input int k, input int budget, output int src);
    src = -1;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (ack_s[k] != '0) begin
        for (int j = 0; j < N; j++) if (ack_s[k][j]) src = j;
        return;
      end
    end
    n_vec++;
    n_bad++;
    $display("FAIL ack timeout inst %0d: got no ack in %0d cycles, required one", k, budget);
  endtask

  task automatic wait_idle(input int k, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (!busy_s[k]) return;
    end
    n_vec++;
    n_bad++;
    $display("FAIL idle timeout inst %0d: busy still 1 after %0d cycles, required 0", k, budget);
  endtask

  task automatic chk_zero(input int k, input string nm);
    chk_i(nm, (int'(ack_s[k]) << 7) | (int'(load_s[k]) << 6) | (int'(fv_s[k]) << 5) |
              (int'(fl_s[k]) << 4) | (int'(src_s[k]) << 1) | int'(busy_s[k]), 0);
    chk_w({nm, " shift_din"}, din_s[k], '0);
  endtask

  logic [W-1:0] wd [4];
  logic [W-1:0] word_a;
  int           s;
  int           bad;

  initial begin
    word_a = 129'h1_0000_0000_0000_0000_0000_0000_0000_0001;
    wd[0]  = 129'h0_DEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
    wd[1]  = 129'h1_5555_AAAA_3333_CCCC_0F0F_F0F0_8001_7FFE;
    wd[2]  = 129'h1_FFFF_0000_FFFF_0000_1234_5678_9ABC_DEF0;
    wd[3]  = 129'h0_8000_0000_0000_0000_0000_0000_0000_0000;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    bif0.req_data = '0;
    bif1.req_data = '0;

    // Reset state
    reset = 1'b0;
    tick(3);
    chk_zero(0, "reset outputs inst0");
    chk_zero(1, "reset outputs inst1");
    reset = 1'b1;
    tick(1);

    // Single word with only its MSB and LSB set
    put_word(0, 0, word_a);
    expect_grant(0, 0, word_a, -1);
    drive(0, 1'b1, 4'b0001);
    tick(1);
    chk_i("single req ack latency", int'(ack_s[0]), 1);
    drive(0, 1'b1, 4'b0000);
    wait_idle(0, 300);

    // All four held after a fresh reset: 0,1,2,3,0 with LOADs WIDTH+3 apart
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    for (int i = 0; i < N; i++) put_word(0, i, wd[i]);
    expect_grant(0, 0, wd[0], -1);
    expect_grant(0, 1, wd[1], W + 3);
    expect_grant(0, 2, wd[2], W + 3);
    expect_grant(0, 3, wd[3], W + 3);
    expect_grant(0, 0, wd[0], W + 3);
    drive(0, 1'b1, 4'b1111);
    for (int i = 0; i < 5; i++) wait_ack(0, 300, s);
    drive(0, 1'b1, 4'b0000);
    wait_idle(0, 300);

    // en low blocks grants; pointer now at 1
    drive(0, 1'b0, 4'b0100);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (ack_s[0] != '0 || busy_s[0]) bad++;
    end
    chk_i("en=0 cycles with ack or busy", bad, 0);
    expect_grant(0, 2, wd[2], -1);
    drive(0, 1'b1, 4'b0100);
    tick(1);
    chk_i("ack after en rises", int'(ack_s[0]), 4);
    drive(0, 1'b1, 4'b0000);
    wait_idle(0, 300);

    // Pointer at 3: req[3] withdrawn before grant, req[1] wins
    drive(0, 1'b0, 4'b1010);
    tick(5);
    drive(0, 1'b0, 4'b0010);
    tick(2);
    expect_grant(0, 1, wd[1], -1);
    drive(0, 1'b1, 4'b0010);
    wait_ack(0, 5, s);
    chk_i("withdrawn req3, granted", s, 1);
    drive(0, 1'b1, 4'b0000);
    wait_idle(0, 300);
    tick(20);

    // Pointer at 2: abort a frame at count 60, then pointer restarts at 0
    expect_grant(0, 2, wd[2], -1);
    drive(0, 1'b1, 4'b0100);
    wait_ack(0, 5, s);
    chk_i("pre-abort grant", s, 2);
    drive(0, 1'b1, 4'b1010);
    tick(61);
    reset = 1'b0;
    #1;
    chk_zero(0, "async reset mid-frame");
    chk_i("aborted frames pending", frm_q.size(), 1);
    if (frm_q.size() > 0) void'(frm_q.pop_front());
    expect_grant(0, 1, wd[1], -1);
    expect_grant(0, 3, wd[3], W + 3);
    tick(2);
    reset = 1'b1;
    wait_ack(0, 5, s);
    chk_i("first grant after reset", s, 1);
    drive(0, 1'b1, 4'b1000);
    wait_ack(0, 300, s);
    chk_i("second grant after reset", s, 3);
    drive(0, 1'b1, 4'b0000);
    wait_idle(0, 300);

    // GAP_CYCLES=0 instance: back-to-back, LOADs WIDTH+2 apart
    put_word(1, 0, wd[2]);
    put_word(1, 1, wd[3]);
    expect_grant(1, 0, wd[2], -1);
    expect_grant(1, 1, wd[3], W + 2);
    drive(1, 1'b1, 4'b0011);
    wait_ack(1, 5, s);
    chk_i("gap0 first grant", s, 0);
    drive(1, 1'b1, 4'b0010);
    wait_ack(1, 300, s);
    chk_i("gap0 second grant", s, 1);
    drive(1, 1'b1, 4'b0000);
    wait_idle(1, 300);
    tick(5);

    chk_i("expectations left unmatched", ack_q.size() + frm_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
